mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one parameter: DATA_FIRST, default 1, which sets the port that wins the first contention after reset (1 = data, 0 = instruction).
REQ-002 clock  in  1  Sole clock; all state updates on the rising edge.
REQ-003 reset  in  1  Asynchronous, active-low reset; state clears immediately while reset=0.
REQ-004 imem_valid  in  1  Instruction-fetch request strobe, one cycle wide.
REQ-005 imem_addr  in  32  Fetch address, sampled with imem_valid.
REQ-006 imem_ready  out  1  One-cycle fetch completion strobe.
REQ-007 imem_rdata  out  32  Fetch data, valid while imem_ready=1.
REQ-008 dmem_valid  in  1  Load/store request strobe, one cycle wide.
REQ-009 dmem_addr  in  32  Data address, sampled with dmem_valid.
REQ-010 dmem_wdata  in  32  Store data, sampled with dmem_valid.
REQ-011 dmem_wstrb  in  4  Byte enables for stores; 0 means load. Sampled with dmem_valid.
REQ-012 dmem_ready  out  1  One-cycle data completion strobe.
REQ-013 dmem_rdata  out  32  Load data, valid while dmem_ready=1.
REQ-014 mem_valid  out  1  Shared-bus request strobe, one cycle per transaction.
REQ-015 mem_instr  out  1  Shared-bus request type: 1 = fetch, 0 = data.
REQ-016 mem_addr  out  32  Shared-bus address.
REQ-017 mem_wdata  out  32  Shared-bus write data.
REQ-018 mem_wstrb  out  4  Shared-bus byte enables; forced to 0 for fetches.
REQ-019 mem_ready  in  1  Shared-bus completion strobe.
REQ-020 mem_rdata  in  32  Shared-bus read data, valid while mem_ready=1.

Function
REQ-021 Each port SHALL have a one-entry pending buffer: valid bit, address, and (data port only) wdata and wstrb. The buffer is loaded on the edge where the port's valid=1 and its pending bit is 0.
REQ-022 A port valid that arrives while that port's pending bit is 1 SHALL be ignored; the buffer contents stay unchanged.
REQ-023 The arbiter SHALL be a two-state FSM:
 - IDLE: no transaction on the shared bus.
 - BUSY: exactly one transaction outstanding; the owner is recorded in a register.
REQ-024 IDLE -> BUSY: on any edge where at least one pending bit is 1, the block SHALL register the following for the next cycle, then clear the granted pending bit:
 - mem_valid=1
 - mem_instr
 - mem_addr, mem_wdata, mem_wstrb from the granted buffer
REQ-025 Latency: a port valid in cycle N with the bus IDLE SHALL produce mem_valid in cycle N+1; buffer load and issue happen on the same edge (bypass).
REQ-026 mem_valid SHALL be high for exactly one cycle per transaction. mem_addr, mem_wdata, mem_wstrb and mem_instr SHALL hold until the transaction completes.
REQ-027 BUSY -> completion: mem_ready=1 in cycle M SHALL produce, in cycle M+1:
 - the owner's ready=1 for one cycle
 - the owner's rdata=mem_rdata sampled in cycle M
 - the other port's ready=0
REQ-028 mem_ready may be 1 no earlier than the cycle after mem_valid.
REQ-029 On the mem_ready edge, the FSM SHALL issue the next pending request directly (BUSY -> BUSY, mem_valid in cycle M+1) or return to IDLE if nothing is pending. This gives back-to-back issue with zero bubble.
REQ-030 mem_ready=1 while IDLE SHALL be ignored: no port ready, no state change.
REQ-031 Contention (both pending bits 1, or one pending plus a same-cycle bypass) SHALL be resolved round-robin: grant goes to the port not granted last. last_grant updates on every grant.
REQ-032 Simultaneous imem_valid and dmem_valid while IDLE SHALL count as contention per REQ-031; the loser is buffered and issued after the winner completes.
REQ-033 A port whose own transaction completes in cycle M may present a new valid in cycle M+1; it SHALL be buffered or bypassed per REQ-021/REQ-025.
REQ-034 imem_rdata and dmem_rdata SHALL hold their last value when the corresponding ready=0.

Reset
REQ-035 While reset=0 the block SHALL hold:
 - FSM in IDLE, both pending bits 0
 - mem_valid, imem_ready, dmem_ready = 0
 - mem_instr, mem_addr, mem_wdata, mem_wstrb, imem_rdata, dmem_rdata = 0
 - last_grant = instruction if DATA_FIRST=1, else data
REQ-036 Reset asserted mid-transaction SHALL discard the outstanding transaction and both buffers. A late mem_ready after reset release falls under REQ-030.

Verification
REQ-037 Single fetch: imem_valid, addr 0x100, in cycle 1; mem_ready with rdata 0x00000013 in cycle 3 -> mem_valid=1 and mem_instr=1 in cycle 2; imem_ready=1 and imem_rdata=0x00000013 in cycle 4.
REQ-038 Contention after reset: imem_valid (0x200) and dmem_valid (0x8000, wstrb 0xF, wdata 0xDEADBEEF) in the same cycle, DATA_FIRST=1 -> the store issues first with mem_wstrb=0xF; the fetch issues in the cycle after the store's mem_ready with mem_wstrb=0.
REQ-039 Round-robin: both ports request continuously for 6 transactions -> grants alternate D,I,D,I,D,I with no idle cycle between mem_ready and the next mem_valid.
REQ-040 Ignored duplicate: dmem_valid at 0x10, then dmem_valid at 0x20 while the first is still pending -> exactly one bus transaction, to 0x10.
REQ-041 Reset mid-operation: reset=0 for one cycle while BUSY, then mem_ready=1 one cycle after release -> no imem_ready or dmem_ready, FSM stays IDLE, all outputs 0.
REQ-042 Spurious mem_ready while IDLE -> no ready strobes and no mem_valid.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single shared memory bus.
// One-entry pending buffer per port, round-robin grant, zero-bubble reissue.
module mem_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_imem_valid,
    input  logic [31:0] i_imem_addr,
    output logic        o_imem_ready,
    output logic [31:0] o_imem_rdata,
    input  logic        i_dmem_valid,
    input  logic [31:0] i_dmem_addr,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_wstrb,
    output logic        o_dmem_ready,
    output logic [31:0] o_dmem_rdata,
    output logic        o_mem_valid,
    output logic        o_mem_instr,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      r_state;
    logic        r_owner_d;
    logic        r_last_d;
    logic        r_i_pend;
    logic [31:0] r_i_addr;
    logic        r_d_pend;
    logic [31:0] r_d_addr;
    logic [31:0] r_d_wdata;
    logic [3:0]  r_d_wstrb;
    logic        r_mem_valid;
    logic        r_mem_instr;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;
    logic        r_imem_ready;
    logic [31:0] r_imem_rdata;
    logic        r_dmem_ready;
    logic [31:0] r_dmem_rdata;

    logic        w_i_req;
    logic [31:0] w_i_addr;
    logic        w_d_req;
    logic [31:0] w_d_addr;
    logic [31:0] w_d_wdata;
    logic [3:0]  w_d_wstrb;
    logic        w_done;
    logic        w_issue;
    logic        w_gnt_d;

    // Effective requests: buffered entry, or a fresh strobe bypassing the buffer
    always_comb begin
        w_i_req   = r_i_pend | i_imem_valid;
        w_i_addr  = r_i_pend ? r_i_addr : i_imem_addr;
        w_d_req   = r_d_pend | i_dmem_valid;
        w_d_addr  = r_d_pend ? r_d_addr : i_dmem_addr;
        w_d_wdata = r_d_pend ? r_d_wdata : i_dmem_wdata;
        w_d_wstrb = r_d_pend ? r_d_wstrb : i_dmem_wstrb;
        w_done    = (r_state == S_BUSY) & i_mem_ready;
        w_issue   = ((r_state == S_IDLE) | w_done) & (w_i_req | w_d_req);
        w_gnt_d   = w_d_req & (~w_i_req | ~r_last_d);
    end

    // Arbiter FSM, pending buffers and all registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_owner_d    <= 1'b0;
            r_last_d     <= ~DATA_FIRST;
            r_i_pend     <= 1'b0;
            r_i_addr     <= '0;
            r_d_pend     <= 1'b0;
            r_d_addr     <= '0;
            r_d_wdata    <= '0;
            r_d_wstrb    <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_instr  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
            r_imem_ready <= 1'b0;
            r_imem_rdata <= '0;
            r_dmem_ready <= 1'b0;
            r_dmem_rdata <= '0;
        end else begin
            r_mem_valid  <= 1'b0;
            r_imem_ready <= w_done & ~r_owner_d;
            r_dmem_ready <= w_done & r_owner_d;
            if (w_done & ~r_owner_d)
                r_imem_rdata <= i_mem_rdata;
            if (w_done & r_owner_d)
                r_dmem_rdata <= i_mem_rdata;

            r_i_pend <= w_i_req;
            r_d_pend <= w_d_req;
            if (i_imem_valid & ~r_i_pend)
                r_i_addr <= i_imem_addr;
            if (i_dmem_valid & ~r_d_pend) begin
                r_d_addr  <= i_dmem_addr;
                r_d_wdata <= i_dmem_wdata;
                r_d_wstrb <= i_dmem_wstrb;
            end

            unique case (r_state)
                S_IDLE: if (w_issue) r_state <= S_BUSY;
                S_BUSY: if (w_done & ~w_issue) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (w_issue) begin
                r_mem_valid <= 1'b1;
                r_mem_instr <= ~w_gnt_d;
                r_mem_addr  <= w_gnt_d ? w_d_addr : w_i_addr;
                r_mem_wdata <= w_gnt_d ? w_d_wdata : 32'h0;
                r_mem_wstrb <= w_gnt_d ? w_d_wstrb : 4'h0;
                r_owner_d   <= w_gnt_d;
                r_last_d    <= w_gnt_d;
                if (w_gnt_d)
                    r_d_pend <= 1'b0;
                else
                    r_i_pend <= 1'b0;
            end
        end
    end

    assign o_mem_valid  = r_mem_valid;
    assign o_mem_instr  = r_mem_instr;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_mem_wstrb  = r_mem_wstrb;
    assign o_imem_ready = r_imem_ready;
    assign o_imem_rdata = r_imem_rdata;
    assign o_dmem_ready = r_dmem_ready;
    assign o_dmem_rdata = r_dmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus
// directed scenarios with literal expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_imem_valid = 1'b0;
    logic [31:0] i_imem_addr = '0;
    logic        i_dmem_valid = 1'b0;
    logic [31:0] i_dmem_addr = '0;
    logic [31:0] i_dmem_wdata = '0;
    logic [3:0]  i_dmem_wstrb = '0;
    logic        i_mem_ready = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_imem_ready, o_dmem_ready, o_mem_valid, o_mem_instr;
    logic [31:0] o_imem_rdata, o_dmem_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_wstrb;

    mem_arbiter #(.DATA_FIRST(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_imem_valid(i_imem_valid), .i_imem_addr(i_imem_addr),
        .o_imem_ready(o_imem_ready), .o_imem_rdata(o_imem_rdata),
        .i_dmem_valid(i_dmem_valid), .i_dmem_addr(i_dmem_addr),
        .i_dmem_wdata(i_dmem_wdata), .i_dmem_wstrb(i_dmem_wstrb),
        .o_dmem_ready(o_dmem_ready), .o_dmem_rdata(o_dmem_rdata),
        .o_mem_valid(o_mem_valid), .o_mem_instr(o_mem_instr),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_wstrb(o_mem_wstrb),
        .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic        v;
        logic [31:0] a;
        logic [31:0] w;
        logic [3:0]  s;
    } req_t;

    req_t        pend [2];
    logic        m_busy;
    int          m_owner;
    int          m_last;
    logic        e_mv, e_instr, e_ir, e_dr;
    logic [31:0] e_addr, e_wd, e_ird, e_drd;
    logic [3:0]  e_ws;

    always @(posedge clk or negedge rst_n) begin
        req_t cand [2];
        int   g;
        logic done;
        if (!rst_n) begin
            pend[0] = '{1'b0, 32'h0, 32'h0, 4'h0};
            pend[1] = '{1'b0, 32'h0, 32'h0, 4'h0};
            m_busy = 0; m_owner = 0; m_last = 0;
            e_mv = 0; e_instr = 0; e_addr = 0; e_wd = 0; e_ws = 0;
            e_ir = 0; e_dr = 0; e_ird = 0; e_drd = 0;
        end else begin
            cand = pend;
            if (!pend[0].v && i_imem_valid)
                cand[0] = '{1'b1, i_imem_addr, 32'h0, 4'h0};
            if (!pend[1].v && i_dmem_valid)
                cand[1] = '{1'b1, i_dmem_addr, i_dmem_wdata, i_dmem_wstrb};
            done = m_busy && i_mem_ready;
            e_ir = done && (m_owner == 0);
            e_dr = done && (m_owner == 1);
            if (e_ir) e_ird = i_mem_rdata;
            if (e_dr) e_drd = i_mem_rdata;
            if (done) m_busy = 0;
            e_mv = 0;
            if (!m_busy && (cand[0].v || cand[1].v)) begin
                if (cand[0].v && cand[1].v) g = 1 - m_last;
                else g = cand[1].v ? 1 : 0;
                e_mv = 1;
                e_instr = (g == 0);
                e_addr = cand[g].a;
                e_wd = cand[g].w;
                e_ws = cand[g].s;
                cand[g].v = 0;
                m_busy = 1; m_owner = g; m_last = g;
            end
            pend = cand;
        end
    end

    // ---------------- monitor / compare ----------------
    typedef struct {
        int          cyc;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_t;
    typedef struct {
        int          cyc;
        logic        port;
        logic [31:0] rdata;
    } rdy_t;

    bus_t blog[$];
    rdy_t rlog[$];

    always @(negedge clk) begin
        chk("mem_valid", {31'b0, o_mem_valid}, {31'b0, e_mv});
        chk("mem_instr", {31'b0, o_mem_instr}, {31'b0, e_instr});
        chk("mem_addr", o_mem_addr, e_addr);
        chk("mem_wdata", o_mem_wdata, e_wd);
        chk("mem_wstrb", {28'b0, o_mem_wstrb}, {28'b0, e_ws});
        chk("imem_ready", {31'b0, o_imem_ready}, {31'b0, e_ir});
        chk("dmem_ready", {31'b0, o_dmem_ready}, {31'b0, e_dr});
        chk("imem_rdata", o_imem_rdata, e_ird);
        chk("dmem_rdata", o_dmem_rdata, e_drd);
        if (o_mem_valid)
            blog.push_back('{cyc, o_mem_instr, o_mem_addr, o_mem_wdata, o_mem_wstrb});
        if (o_imem_ready) rlog.push_back('{cyc, 1'b0, o_imem_rdata});
        if (o_dmem_ready) rlog.push_back('{cyc, 1'b1, o_dmem_rdata});
    end

    // ---------------- auto memory responder ----------------
    logic        auto_resp = 1'b1;
    int          resp_lat  = 1;
    logic [31:0] resp_xor  = 32'h0;
    int          rcnt = 0;
    logic [31:0] rla  = '0;

    always @(negedge clk) begin
        if (!rst_n) rcnt = 0;
        if (auto_resp) begin
            i_mem_ready = 1'b0;
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    i_mem_ready = 1'b1;
                    i_mem_rdata = rla ^ resp_xor;
                end
            end
            if (o_mem_valid) begin
                rcnt = resp_lat;
                rla  = o_mem_addr;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        i_imem_valid = 0; i_dmem_valid = 0;
        rst_n = 0;
        step(2);
        rst_n = 1;
        blog.delete();
        rlog.delete();
        step(1);
    endtask

    task automatic drive(logic iv, logic [31:0] ia, logic dv,
                         logic [31:0] da, logic [31:0] dw, logic [3:0] ds);
        i_imem_valid = iv; i_imem_addr = ia;
        i_dmem_valid = dv; i_dmem_addr = da;
        i_dmem_wdata = dw; i_dmem_wstrb = ds;
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic [31:0] dw;
        logic [3:0]  ds;
    } vec_t;

    vec_t mix [12];
    int   c0;

    initial begin
        mix[0]  = '{1, 32'h0000_0400, 0, 32'h0,         32'h0,         4'h0};
        mix[1]  = '{0, 32'h0,         1, 32'h0000_9000, 32'h1111_2222, 4'h3};
        mix[2]  = '{1, 32'h0000_0404, 0, 32'h0,         32'h0,         4'h0};
        mix[3]  = '{0, 32'h0,         0, 32'h0,         32'h0,         4'h0};
        mix[4]  = '{1, 32'h0000_0408, 1, 32'h0000_9004, 32'h0,         4'h0};
        mix[5]  = '{0, 32'h0,         0, 32'h0,         32'h0,         4'h0};
        mix[6]  = '{0, 32'h0,         1, 32'h0000_9008, 32'hCAFE_F00D, 4'hC};
        mix[7]  = '{1, 32'h0000_040C, 0, 32'h0,         32'h0,         4'h0};
        mix[8]  = '{1, 32'h0000_0410, 1, 32'h0000_900C, 32'h5555_AAAA, 4'h1};
        mix[9]  = '{0, 32'h0,         0, 32'h0,         32'h0,         4'h0};
        mix[10] = '{0, 32'h0,         1, 32'h0000_9010, 32'h0,         4'h0};
        mix[11] = '{1, 32'h0000_0414, 0, 32'h0,         32'h0,         4'h0};

        // reset state
        step(1);
        chk("rst_mem_valid", {31'b0, o_mem_valid}, 32'h0);
        chk("rst_mem_addr", o_mem_addr, 32'h0);
        chk("rst_imem_rdata", o_imem_rdata, 32'h0);
        rst_n = 1;
        step(1);

        // single fetch
        do_reset();
        resp_lat = 1; resp_xor = 32'h0000_0113;
        c0 = cyc;
        drive(1, 32'h100, 0, 0, 0, 0);
        step(1);
        drive(0, 0, 0, 0, 0, 0);
        step(6);
        chk("t1_nbus", blog.size(), 1);
        chk("t1_nrdy", rlog.size(), 1);
        if (blog.size() >= 1) begin
            chk("t1_cyc", blog[0].cyc, c0 + 1);
            chk("t1_instr", {31'b0, blog[0].instr}, 32'h1);
            chk("t1_addr", blog[0].addr, 32'h100);
        end
        if (rlog.size() >= 1) begin
            chk("t1_rcyc", rlog[0].cyc, c0 + 3);
            chk("t1_rport", {31'b0, rlog[0].port}, 32'h0);
            chk("t1_rdata", rlog[0].rdata, 32'h0000_0013);
        end

        // contention after reset: store wins
        do_reset();
        resp_xor = 32'h0000_0001;
        c0 = cyc;
        drive(1, 32'h200, 1, 32'h8000, 32'hDEAD_BEEF, 4'hF);
        step(1);
        drive(0, 0, 0, 0, 0, 0);
        step(8);
        chk("t2_nbus", blog.size(), 2);
        if (blog.size() >= 2) begin
            chk("t2_d_instr", {31'b0, blog[0].instr}, 32'h0);
            chk("t2_d_addr", blog[0].addr, 32'h8000);
            chk("t2_d_wdata", blog[0].wdata, 32'hDEAD_BEEF);
            chk("t2_d_wstrb", {28'b0, blog[0].wstrb}, 32'hF);
            chk("t2_d_cyc", blog[0].cyc, c0 + 1);
            chk("t2_i_instr", {31'b0, blog[1].instr}, 32'h1);
            chk("t2_i_addr", blog[1].addr, 32'h200);
            chk("t2_i_wstrb", {28'b0, blog[1].wstrb}, 32'h0);
            chk("t2_i_cyc", blog[1].cyc, c0 + 3);
        end
        if (rlog.size() >= 1)
            chk("t2_drdata", rlog[0].rdata, 32'h0000_8001);

        // round robin with continuous requests
        do_reset();
        c0 = cyc;
        for (int k = 0; k < 14; k++) begin
            drive(1, 32'h1000 + 32'(k * 4), 1, 32'h2000 + 32'(k * 4),
                  32'(k), 4'h0);
            step(1);
        end
        drive(0, 0, 0, 0, 0, 0);
        step(10);
        chk("t3_nbus_ge6", {31'b0, blog.size() >= 6}, 32'h1);
        if (blog.size() >= 6) begin
            chk("t3_first_addr", blog[0].addr, 32'h2000);
            chk("t3_first_cyc", blog[0].cyc, c0 + 1);
            for (int k = 0; k < 6; k++) begin
                chk("t3_grant", {31'b0, blog[k].instr}, 32'(k % 2));
                chk("t3_gap", blog[k].cyc, blog[0].cyc + 2 * k);
            end
        end

        // duplicate data request while pending is dropped
        do_reset();
        resp_lat = 4;
        drive(1, 32'h300, 0, 0, 0, 0);
        step(1);
        drive(0, 0, 1, 32'h10, 32'h0, 4'h0);
        step(1);
        drive(0, 0, 1, 32'h20, 32'h0, 4'h0);
        step(1);
        drive(0, 0, 0, 0, 0, 0);
        step(16);
        chk("t4_nbus", blog.size(), 2);
        if (blog.size() >= 2) begin
            chk("t4_d_addr", blog[1].addr, 32'h10);
            chk("t4_d_instr", {31'b0, blog[1].instr}, 32'h0);
        end

        // reset mid-transaction, late mem_ready afterwards
        do_reset();
        auto_resp = 0;
        i_mem_ready = 0;
        drive(1, 32'h400, 0, 0, 0, 0);
        step(1);
        drive(0, 0, 0, 0, 0, 0);
        step(1);
        rst_n = 0;
        blog.delete();
        rlog.delete();
        step(1);
        rst_n = 1;
        step(1);
        i_mem_ready = 1; i_mem_rdata = 32'h1234_5678;
        step(1);
        i_mem_ready = 0;
        step(3);
        chk("t5_nbus", blog.size(), 0);
        chk("t5_nrdy", rlog.size(), 0);
        chk("t5_addr", o_mem_addr, 32'h0);
        chk("t5_irdata", o_imem_rdata, 32'h0);

        // spurious mem_ready while idle
        do_reset();
        i_mem_ready = 1; i_mem_rdata = 32'hFFFF_FFFF;
        step(1);
        i_mem_ready = 0;
        step(3);
        chk("t6_nbus", blog.size(), 0);
        chk("t6_nrdy", rlog.size(), 0);
        chk("t6_drdata", o_dmem_rdata, 32'h0);

        // mixed traffic, model-checked, slower memory
        do_reset();
        auto_resp = 1;
        resp_lat = 2;
        resp_xor = 32'hA5A5_0000;
        for (int k = 0; k < 12; k++) begin
            drive(mix[k].iv, mix[k].ia, mix[k].dv, mix[k].da,
                  mix[k].dw, mix[k].ds);
            step(1);
        end
        drive(0, 0, 0, 0, 0, 0);
        step(20);
        chk("t7_nrdy", rlog.size(), blog.size());

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
